instr_fetch_ctrl: RTL and testbench

//  Fetch sequencer for the 16x8 instruction memory of the 8-bit CPU. Owns the program counter
//  and drives the memory's address/read-enable pins. Captures each word into an instruction

---
 rtl/instr_fetch_ctrl_pkg.sv | 17 +
 rtl/instr_fetch_ctrl.sv | 112 +++++++++++
 tb/tb_instr_fetch_ctrl.sv | 340 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_ctrl_pkg.sv
// instr_fetch_ctrl_pkg: shared fetch parameters and FSM state encoding
// Default geometry of the 16x8 instruction memory, the HALT opcode, and the
// fetch-sequencer state encoding reused by the decode stage.
package instr_fetch_ctrl_pkg;

    localparam int          DEF_AW          = 4;
    localparam int          DEF_DW          = 8;
    localparam logic [7:0]  DEF_HALT_OPCODE = 8'hFF;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_ISSUE = 2'd2,
        ST_HALT  = 2'd3
    } state_t;

endpackage

// File: rtl/instr_fetch_ctrl.sv
// instr_fetch_ctrl: PC owner and fetch sequencer for the 8-bit CPU instruction memory
// Ports:
//   clk_i, rst_i                    clock, asynchronous active-high reset
//   start_i                         begin fetching at address 0 (IDLE/HALT only)
//   imem_addr_o, imem_read_o        instruction memory address / read enable
//   imem_data_i                     combinational read data from memory
//   ir_o, pc_o, ir_valid_o          instruction register, its address, valid flag
//   ir_ready_i                      decoder accept
//   redirect_i, redirect_addr_i     taken-branch pulse and target
//   halted_o                        HALT opcode reached, fetching stopped
module instr_fetch_ctrl
    import instr_fetch_ctrl_pkg::*;
#(
    parameter int            AW          = DEF_AW,
    parameter int            DW          = DEF_DW,
    parameter logic [DW-1:0] HALT_OPCODE = DW'(DEF_HALT_OPCODE)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          start_i,
    output logic [AW-1:0] imem_addr_o,
    output logic          imem_read_o,
    input  logic [DW-1:0] imem_data_i,
    output logic [DW-1:0] ir_o,
    output logic [AW-1:0] pc_o,
    output logic          ir_valid_o,
    input  logic          ir_ready_i,
    input  logic          redirect_i,
    input  logic [AW-1:0] redirect_addr_i,
    output logic          halted_o
);

    state_t        state_q, state_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [DW-1:0] ir_q, ir_d;
    logic [AW-1:0] ir_pc_q, ir_pc_d;
    logic          valid_q, valid_d;
    logic          halted_q, halted_d;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= ST_IDLE;
            pc_q     <= '0;
            ir_q     <= '0;
            ir_pc_q  <= '0;
            valid_q  <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            ir_pc_q  <= ir_pc_d;
            valid_q  <= valid_d;
            halted_q <= halted_d;
        end
    end

    // Redirect outranks both the FETCH capture and the ISSUE handshake, so a
    // taken branch always discards whatever word is in flight.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ir_d     = ir_q;
        ir_pc_d  = ir_pc_q;
        valid_d  = valid_q;
        halted_d = halted_q;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    pc_d    = '0;
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (redirect_i) begin
                    pc_d = redirect_addr_i;
                end else if (imem_data_i == HALT_OPCODE) begin
                    halted_d = 1'b1;
                    state_d  = ST_HALT;
                end else begin
                    ir_d    = imem_data_i;
                    ir_pc_d = pc_q;
                    pc_d    = pc_q + AW'(1);
                    valid_d = 1'b1;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (redirect_i || ir_ready_i) begin
                    valid_d = 1'b0;
                    state_d = ST_FETCH;
                    pc_d    = redirect_i ? redirect_addr_i : pc_q;
                end
            end
            ST_HALT: begin
                if (start_i) begin
                    halted_d = 1'b0;
                    pc_d     = '0;
                    state_d  = ST_FETCH;
                end
            end
        endcase
    end

    assign imem_addr_o = pc_q;
    assign imem_read_o = (state_q == ST_FETCH);
    assign ir_o        = ir_q;
    assign pc_o        = ir_pc_q;
    assign ir_valid_o  = valid_q;
    assign halted_o    = halted_q;

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// tb_instr_fetch_ctrl: scenario and randomized checks of the fetch sequencer
module tb_instr_fetch_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [3:0] imem_addr;
    logic       imem_read;
    logic [7:0] imem_data;
    logic [7:0] ir;
    logic [3:0] pc;
    logic       valid;
    logic       ready;
    logic       redirect;
    logic [3:0] redirect_addr;
    logic       halted;

    logic [7:0] mem [16];
    int         n_chk  = 0;
    int         n_pass = 0;

    assign imem_data = mem[imem_addr];

    always #5 clk = ~clk;

    instr_fetch_ctrl dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .start_i        (start),
        .imem_addr_o    (imem_addr),
        .imem_read_o    (imem_read),
        .imem_data_i    (imem_data),
        .ir_o           (ir),
        .pc_o           (pc),
        .ir_valid_o     (valid),
        .ir_ready_i     (ready),
        .redirect_i     (redirect),
        .redirect_addr_i(redirect_addr),
        .halted_o       (halted)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_default();
        logic [7:0] img [16];
        img = '{8'h00, 8'h20, 8'h11, 8'h00, 8'h81, 8'hD3, 8'hC8, 8'h00,
                8'h00, 8'h91, 8'h48, 8'h28, 8'hFF, 8'h00, 8'h00, 8'h00};
        for (int i = 0; i < 16; i++) mem[i] = img[i];
    endtask

    task automatic test_reset();
        n_chk++;
        if ({imem_addr, imem_read, ir, pc, valid, halted} !== 19'd0)
            $display("FAIL reset_state: got addr=%0h read=%b ir=%h pc=%0h valid=%b halted=%b, want all 0",
                     imem_addr, imem_read, ir, pc, valid, halted);
        else n_pass++;
        rst = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        ready = 1'b0;
        tick();
        n_chk++;
        if ({valid, ir, pc} !== {1'b1, mem[0], 4'd0})
            $display("FAIL reset_setup_issue: got valid=%b ir=%h pc=%0h, want 1/%h/0", valid, ir, pc, mem[0]);
        else n_pass++;
        #3 rst = 1'b1;
        #1;
        n_chk++;
        if ({imem_addr, imem_read, ir, pc, valid, halted} !== 19'd0)
            $display("FAIL reset_async: got addr=%0h read=%b ir=%h pc=%0h valid=%b halted=%b, want all 0",
                     imem_addr, imem_read, ir, pc, valid, halted);
        else n_pass++;
        #2 rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            n_chk++;
            if ({imem_read, valid, halted} !== 3'b000)
                $display("FAIL reset_idle: cycle %0d got read=%b valid=%b halted=%b, want 000",
                         c, imem_read, valid, halted);
            else n_pass++;
        end
    endtask

    task automatic test_sequence();
        int exp_cnt = 0;
        int got     = 0;
        int last    = -1;
        while (exp_cnt < 16 && mem[exp_cnt] != 8'hFF) exp_cnt++;
        ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 0; c < 80 && !halted; c++) begin
            tick();
            if (valid) begin
                n_chk++;
                if ({ir, pc} !== {mem[got], 4'(got)} || (last >= 0 && c - last != 2))
                    $display("FAIL seq_issue: #%0d got ir=%h pc=%0h gap=%0d, want ir=%h pc=%0h gap=2",
                             got, ir, pc, c - last, mem[got], got);
                else n_pass++;
                last = c;
                got++;
            end
        end
        n_chk++;
        if (got !== exp_cnt || halted !== 1'b1 || imem_read !== 1'b0)
            $display("FAIL seq_halt: got issued=%0d halted=%b read=%b, want issued=%0d halted=1 read=0",
                     got, halted, imem_read, exp_cnt);
        else n_pass++;
    endtask

    task automatic test_backpressure();
        bit found = 0;
        start = 1'b1;
        ready = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 0; c < 10 && !found; c++) begin
            tick();
            found = valid && pc == 4'd1;
        end
        ready = 1'b0;
        n_chk++;
        if (!found) $display("FAIL bp_reach: pc_o=1 never issued, got pc=%0h valid=%b", pc, valid);
        else n_pass++;
        for (int c = 0; c < 3; c++) begin
            tick();
            n_chk++;
            if ({valid, ir, pc, imem_read} !== {1'b1, mem[1], 4'd1, 1'b0})
                $display("FAIL bp_hold: cycle %0d got valid=%b ir=%h pc=%0h read=%b, want 1/%h/1/0",
                         c, valid, ir, pc, imem_read, mem[1]);
            else n_pass++;
        end
        ready = 1'b1;
        tick();
        n_chk++;
        if (valid !== 1'b0) $display("FAIL bp_drop: got valid=%b, want 0", valid);
        else n_pass++;
        tick();
        n_chk++;
        if ({valid, ir, pc} !== {1'b1, mem[2], 4'd2})
            $display("FAIL bp_next: got valid=%b ir=%h pc=%0h, want 1/%h/2", valid, ir, pc, mem[2]);
        else n_pass++;
    endtask

    task automatic test_redirect();
        int exp = 10;
        redirect = 1'b1;
        redirect_addr = 4'd9;
        tick();
        redirect = 1'b0;
        n_chk++;
        if (valid !== 1'b0) $display("FAIL redir_drop: got valid=%b, want 0", valid);
        else n_pass++;
        tick();
        n_chk++;
        if ({valid, ir, pc} !== {1'b1, mem[9], 4'd9})
            $display("FAIL redir_target: got valid=%b ir=%h pc=%0h, want 1/%h/9", valid, ir, pc, mem[9]);
        else n_pass++;
        for (int c = 0; c < 20 && !halted; c++) begin
            tick();
            if (valid) begin
                n_chk++;
                if (pc !== 4'(exp) || (pc >= 4'd3 && pc <= 4'd8))
                    $display("FAIL redir_stream: got pc=%0h, want %0h", pc, exp);
                else n_pass++;
                exp++;
            end
        end
        n_chk++;
        if (exp !== 12 || halted !== 1'b1)
            $display("FAIL redir_end: got next=%0d halted=%b, want 12/1", exp, halted);
        else n_pass++;
    endtask

    task automatic test_wrap();
        mem[15] = 8'h5A;
        mem[0]  = 8'h33;
        ready = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        n_chk++;
        if ({valid, ir, pc} !== {1'b1, 8'h33, 4'd0})
            $display("FAIL wrap_first: got valid=%b ir=%h pc=%0h, want 1/33/0", valid, ir, pc);
        else n_pass++;
        redirect = 1'b1;
        redirect_addr = 4'd15;
        tick();
        redirect = 1'b0;
        tick();
        n_chk++;
        if ({valid, ir, pc} !== {1'b1, 8'h5A, 4'd15})
            $display("FAIL wrap_15: got valid=%b ir=%h pc=%0h, want 1/5a/f", valid, ir, pc);
        else n_pass++;
        ready = 1'b1;
        tick();
        ready = 1'b0;
        tick();
        n_chk++;
        if ({valid, ir, pc} !== {1'b1, 8'h33, 4'd0})
            $display("FAIL wrap_0: got valid=%b ir=%h pc=%0h, want 1/33/0", valid, ir, pc);
        else n_pass++;
        redirect = 1'b1;
        redirect_addr = 4'd12;
        tick();
        redirect = 1'b0;
        tick();
        n_chk++;
        if ({halted, valid} !== 2'b10)
            $display("FAIL wrap_halt: got halted=%b valid=%b, want 1/0", halted, valid);
        else n_pass++;
        load_default();
    endtask

    task automatic test_halt_ignore();
        logic [7:0] ir0 = ir;
        logic [3:0] pc0 = pc;
        for (int c = 0; c < 4; c++) begin
            redirect = 1'b1;
            redirect_addr = 4'($urandom_range(0, 15));
            ready = c[0];
            tick();
            n_chk++;
            if ({halted, valid, imem_read, ir, pc} !== {3'b100, ir0, pc0})
                $display("FAIL halt_hold: cycle %0d got halted=%b valid=%b read=%b ir=%h pc=%0h, want 1/0/0/%h/%0h",
                         c, halted, valid, imem_read, ir, pc, ir0, pc0);
            else n_pass++;
        end
        redirect = 1'b0;
        ready = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        n_chk++;
        if ({halted, imem_read, imem_addr} !== {2'b01, 4'd0})
            $display("FAIL halt_restart: got halted=%b read=%b addr=%0h, want 0/1/0", halted, imem_read, imem_addr);
        else n_pass++;
        tick();
        n_chk++;
        if ({valid, ir, pc} !== {1'b1, 8'h00, 4'd0})
            $display("FAIL halt_first: got valid=%b ir=%h pc=%0h, want 1/00/0", valid, ir, pc);
        else n_pass++;
    endtask

    // Transaction-level model: exp_pc is the address of the next word the
    // decoder must see; it advances on acceptance, jumps on redirect and
    // restarts at 0 on start from HALT.
    task automatic test_random();
        logic [3:0] exp_pc = 4'd0;
        logic       v0, h0, r, rd, st;
        logic [7:0] ir0;
        logic [3:0] pc0, ra;
        for (int i = 0; i < 16; i++)
            mem[i] = ($urandom_range(0, 9) == 0) ? 8'hFF : 8'($urandom_range(0, 254));
        ready = 1'b0;
        redirect = 1'b0;
        start = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        start = 1'b1;
        tick();
        for (int c = 0; c < 600; c++) begin
            v0 = valid;
            h0 = halted;
            ir0 = ir;
            pc0 = pc;
            r  = 1'($urandom_range(0, 1));
            rd = ($urandom_range(0, 5) == 0);
            ra = 4'($urandom_range(0, 15));
            st = ($urandom_range(0, 2) == 0);
            ready = r;
            redirect = rd;
            redirect_addr = ra;
            start = st;
            if (h0) begin
                if (st) exp_pc = 4'd0;
            end else if (rd) exp_pc = ra;
            else if (v0 && r) exp_pc = pc0 + 4'd1;
            tick();
            n_chk++;
            if (h0) begin
                if ({halted, valid} !== {!st, 1'b0})
                    $display("FAIL rnd_halt: cycle %0d start=%b got halted=%b valid=%b", c, st, halted, valid);
                else n_pass++;
            end else if (rd || (v0 && r)) begin
                if ({halted, valid} !== 2'b00)
                    $display("FAIL rnd_consume: cycle %0d got halted=%b valid=%b, want 0/0", c, halted, valid);
                else n_pass++;
            end else if (v0) begin
                if ({valid, ir, pc} !== {1'b1, ir0, pc0})
                    $display("FAIL rnd_stall: cycle %0d got valid=%b ir=%h pc=%0h, want 1/%h/%0h",
                             c, valid, ir, pc, ir0, pc0);
                else n_pass++;
            end else if (mem[exp_pc] == 8'hFF) begin
                if ({halted, valid} !== 2'b10)
                    $display("FAIL rnd_halt_op: cycle %0d pc=%0h got halted=%b valid=%b, want 1/0",
                             c, exp_pc, halted, valid);
                else n_pass++;
            end else begin
                if ({halted, valid, ir, pc} !== {2'b01, mem[exp_pc], exp_pc})
                    $display("FAIL rnd_issue: cycle %0d got halted=%b valid=%b ir=%h pc=%0h, want 0/1/%h/%0h",
                             c, halted, valid, ir, pc, mem[exp_pc], exp_pc);
                else n_pass++;
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        ready = 1'b0;
        redirect = 1'b0;
        redirect_addr = 4'd0;
        load_default();
        #12;
        test_reset();
        test_sequence();
        test_backpressure();
        test_redirect();
        test_wrap();
        test_halt_ignore();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_chk);
        $fatal(1);
    end

endmodule
